// File: rtl/instr_fetch_issue.sv
// Fetch/decode/issue sequencer: FETCH -> WAIT(RAM_LAT) -> DECODE -> ISSUE, period RAM_LAT+3 cycles.
// ISSUE holds all issue fields stable until i_issue_ready; branch and halt are consumed locally.
module instr_fetch_issue #(
    parameter int         RAM_LAT  = 1,
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [3:0] OPC_BR   = 4'b1100,
    parameter logic [3:0] OPC_HALT = 4'b1111
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_fetch_req,
    output logic [15:0] o_fetch_addr,
    input  logic [31:0] i_instr_in,
    output logic [3:0]  o_rs1_addr,
    output logic [3:0]  o_rs2_addr,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    output logic        o_issue_valid,
    input  logic        i_issue_ready,
    output logic [3:0]  o_opcode,
    output logic [3:0]  o_rd,
    output logic [31:0] o_src1,
    output logic [31:0] o_src2,
    output logic [7:0]  o_pc_out,
    output logic        o_halted
);

    typedef enum logic [2:0] {S_FETCH, S_WAIT, S_DECODE, S_ISSUE, S_HALT} state_t;

    localparam logic [3:0] LAT_M1 = 4'(RAM_LAT - 1);

    state_t      r_state, w_next;
    logic [7:0]  r_pc, w_pc_next;
    logic [31:0] r_ir, r_src1, r_src2;
    logic [3:0]  r_wait_cnt, w_wait_next;
    logic        r_fetch_req;
    logic        w_ir_load, w_src_load;
    logic        w_unused_imm_hi;

    assign w_unused_imm_hi = ^r_ir[15:8];

    // The strobe is a register, so the first cycle after reset sits in FETCH with
    // no strobe; FETCH only advances once the strobe has actually been driven.
    always_comb begin
        w_next      = r_state;
        w_pc_next   = r_pc;
        w_wait_next = r_wait_cnt;
        w_ir_load   = 1'b0;
        w_src_load  = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (r_fetch_req) begin
                    w_wait_next = LAT_M1;
                    w_next      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_ir_load = 1'b1;
                    w_next    = S_DECODE;
                end else begin
                    w_wait_next = r_wait_cnt - 4'd1;
                end
            end
            S_DECODE: begin
                w_src_load = 1'b1;
                if (r_ir[31:28] == OPC_HALT) begin
                    w_next = S_HALT;
                end else if (r_ir[31:28] == OPC_BR) begin
                    w_pc_next = r_ir[7:0];
                    w_next    = S_FETCH;
                end else begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_issue_ready) begin
                    w_pc_next = r_pc + 8'd1;
                    w_next    = S_FETCH;
                end
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_ir        <= 32'd0;
            r_src1      <= 32'd0;
            r_src2      <= 32'd0;
            r_wait_cnt  <= 4'd0;
            r_fetch_req <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_pc        <= w_pc_next;
            r_wait_cnt  <= w_wait_next;
            r_fetch_req <= (w_next == S_FETCH);
            if (w_ir_load) begin
                r_ir <= i_instr_in;
            end
            if (w_src_load) begin
                r_src1 <= i_rs1_data;
                r_src2 <= i_rs2_data;
            end
        end
    end

    assign o_fetch_req   = r_fetch_req;
    assign o_fetch_addr  = {8'h00, r_pc};
    assign o_rs1_addr    = r_ir[23:20];
    assign o_rs2_addr    = r_ir[19:16];
    assign o_issue_valid = (r_state == S_ISSUE);
    assign o_opcode      = r_ir[31:28];
    assign o_rd          = r_ir[27:24];
    assign o_src1        = r_src1;
    assign o_src2        = r_src2;
    assign o_pc_out      = o_issue_valid ? r_pc : 8'h00;
    assign o_halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Two DUTs (RAM_LAT=1/RESET_PC=00, RAM_LAT=3/RESET_PC=FD) share memory, regfile, ready and reset.
// A program-level model predicts fetch and issue streams; negedge monitors score them.
module tb_instr_fetch_issue;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [7:0]  pc;
    } iss_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic ready = 1'b1;
    int   rmode = 0;

    logic [31:0] mem [0:255];
    logic [31:0] rf  [0:15];

    logic        fr [2];
    logic [15:0] fa [2];
    logic [31:0] ins [2];
    logic [3:0]  r1a [2], r2a [2];
    logic [31:0] r1d [2], r2d [2];
    logic        iv [2];
    logic [3:0]  op [2], rdo [2];
    logic [31:0] s1 [2], s2 [2];
    logic [7:0]  pco [2];
    logic        hl [2];

    int         lat [2] = '{1, 3};
    logic [7:0] rpc [2] = '{8'h00, 8'hFD};

    assign r1d[0] = rf[r1a[0]];
    assign r2d[0] = rf[r2a[0]];
    assign r1d[1] = rf[r1a[1]];
    assign r2d[1] = rf[r2a[1]];

    instr_fetch_issue #(.RAM_LAT(1), .RESET_PC(8'h00)) u0 (
        .i_clk(clk), .i_reset(reset), .o_fetch_req(fr[0]), .o_fetch_addr(fa[0]),
        .i_instr_in(ins[0]), .o_rs1_addr(r1a[0]), .o_rs2_addr(r2a[0]),
        .i_rs1_data(r1d[0]), .i_rs2_data(r2d[0]), .o_issue_valid(iv[0]),
        .i_issue_ready(ready), .o_opcode(op[0]), .o_rd(rdo[0]), .o_src1(s1[0]),
        .o_src2(s2[0]), .o_pc_out(pco[0]), .o_halted(hl[0]));

    instr_fetch_issue #(.RAM_LAT(3), .RESET_PC(8'hFD)) u1 (
        .i_clk(clk), .i_reset(reset), .o_fetch_req(fr[1]), .o_fetch_addr(fa[1]),
        .i_instr_in(ins[1]), .o_rs1_addr(r1a[1]), .o_rs2_addr(r2a[1]),
        .i_rs1_data(r1d[1]), .i_rs2_data(r2d[1]), .o_issue_valid(iv[1]),
        .i_issue_ready(ready), .o_opcode(op[1]), .o_rd(rdo[1]), .o_src1(s1[1]),
        .o_src2(s2[1]), .o_pc_out(pco[1]), .o_halted(hl[1]));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] ef [2][0:511];
    iss_t        ei [2][0:511];
    int          ef_n [2], ef_h [2], ei_n [2], ei_h [2];

    int   ram_cnt [2] = '{0, 0};
    logic [7:0] ram_a [2];
    logic hold [2] = '{1'b0, 1'b0};
    iss_t held [2];
    iss_t mon_c;

    int   fc [0:7];
    int   nfc, acc [0:7], nacc, first_iv, low_cnt;
    iss_t first_iss;

    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic iss_t cur(input int k);
        iss_t c;
        c.op = op[k]; c.rd = rdo[k]; c.s1 = s1[k]; c.s2 = s2[k]; c.pc = pco[k];
        return c;
    endfunction

    // RAM: data is only meaningful in the cycle exactly RAM_LAT after the strobe.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (ram_cnt[k] == 1) ins[k] = mem[ram_a[k]];
            else                 ins[k] = $urandom;
            if (ram_cnt[k] > 0) ram_cnt[k]--;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            hold[0] = 1'b0;
            hold[1] = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (fr[k]) begin
                    ram_cnt[k] = lat[k];
                    ram_a[k]   = fa[k][7:0];
                    if (k == 0 && nfc < 8) begin fc[nfc] = cyc; nfc++; end
                    if (ef_h[k] >= ef_n[k]) begin
                        checks++; errors++;
                        $display("FAIL unexpected_fetch inst%0d actual addr=%h required none", k, fa[k]);
                    end else begin
                        chk($sformatf("fetch_addr%0d", k), 96'(fa[k]), 96'(ef[k][ef_h[k]]));
                        ef_h[k]++;
                    end
                end
                if (iv[k]) begin
                    mon_c = cur(k);
                    if (k == 0 && first_iv < 0) first_iv = cyc;
                    if (hold[k]) chk($sformatf("hold_stable%0d", k), 96'(mon_c), 96'(held[k]));
                    if (ready) begin
                        if (k == 0) begin
                            if (nacc == 0) first_iss = mon_c;
                            if (nacc < 8) acc[nacc] = cyc;
                            nacc++;
                        end
                        if (ei_h[k] >= ei_n[k]) begin
                            checks++; errors++;
                            $display("FAIL unexpected_issue inst%0d actual=%h required none", k, mon_c);
                        end else begin
                            chk($sformatf("issue%0d", k), 96'(mon_c), 96'(ei[k][ei_h[k]]));
                            ei_h[k]++;
                        end
                        hold[k] = 1'b0;
                    end else begin
                        hold[k] = 1'b1;
                        held[k] = mon_c;
                        if (k == 0) low_cnt++;
                    end
                end else if (hold[k]) begin
                    checks++; errors++;
                    $display("FAIL valid_dropped inst%0d actual valid=0 required 1", k);
                    hold[k] = 1'b0;
                end
            end
        end
    end

    // Program-level model: walk memory from the start pc until a halt.
    task automatic predict(input int k, input logic [7:0] start);
        logic [7:0]  pc;
        logic [31:0] w;
        iss_t        e;
        pc = start;
        for (int n = 0; n < 400; n++) begin
            w = mem[pc];
            ef[k][ef_n[k]] = {8'h00, pc};
            ef_n[k]++;
            if (w[31:28] == 4'hF) break;
            if (w[31:28] == 4'hC) begin
                pc = w[7:0];
            end else begin
                e.op = w[31:28]; e.rd = w[27:24];
                e.s1 = rf[w[23:20]]; e.s2 = rf[w[19:16]]; e.pc = pc;
                ei[k][ei_n[k]] = e;
                ei_n[k]++;
                pc = pc + 8'd1;
            end
        end
    endtask

    function automatic logic [31:0] rand_alu();
        int o;
        o = $urandom_range(0, 13);
        if (o >= 12) o++;
        return {4'(o), 28'($urandom)};
    endfunction

    task automatic fill_alu();
        for (int a = 0; a < 256; a++) mem[a] = rand_alu();
        for (int r = 0; r < 16; r++) rf[r] = $urandom;
    endtask

    task automatic gen_random();
        int kk;
        fill_alu();
        kk = $urandom_range(8, 40);
        for (int a = 0; a < kk; a++)
            if ($urandom_range(0, 4) == 0)
                mem[a] = {4'hC, 20'($urandom), 8'($urandom_range(a + 1, kk))};
        mem[kk] = {4'hF, 28'($urandom)};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ready = (rmode != 0) ? ($urandom_range(0, 2) != 0) : !(cyc >= 8 && cyc <= 12);
    endtask

    task automatic flush();
        for (int k = 0; k < 2; k++) begin
            ef_n[k] = 0; ef_h[k] = 0; ei_n[k] = 0; ei_h[k] = 0;
        end
        nfc = 0; nacc = 0; first_iv = -1; low_cnt = 0;
    endtask

    task automatic release_and_check();
        reset = 1'b0;
        predict(0, rpc[0]);
        predict(1, rpc[1]);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset_outputs%0d", k),
                96'({fr[k], iv[k], hl[k], op[k], rdo[k], r1a[k], r2a[k], s1[k], s2[k], pco[k]}), 96'd0);
            chk($sformatf("reset_fetch_addr%0d", k), 96'(fa[k]), 96'({8'h00, rpc[k]}));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush();
        step();
        step();
        release_and_check();
    endtask

    task automatic run_to_halt(input string tag);
        for (int n = 0; n < 3000; n++) begin
            if (hl[0] && hl[1]) break;
            step();
        end
        for (int n = 0; n < 6; n++) step();
        chk({tag, "_halted"}, 96'({hl[0], hl[1], fr[0], fr[1]}), 96'(4'b1100));
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_fetches_done%0d", tag, k), 96'(ef_h[k]), 96'(ef_n[k]));
            chk($sformatf("%s_issues_done%0d", tag, k), 96'(ei_h[k]), 96'(ei_n[k]));
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 32'd0;
        for (int r = 0; r < 16; r++) rf[r] = 32'd0;
        ins[0] = 32'd0;
        ins[1] = 32'd0;
        flush();

        // Directed: first issue timing, 5-cycle stall, halt; u1 also wraps FF -> 00.
        fill_alu();
        mem[0] = 32'hA1230000;
        mem[1] = 32'hB0450000;
        mem[2] = 32'hF0000000;
        rf[2]  = 32'd3;
        rf[3]  = 32'd33;
        rmode  = 0;
        do_reset();
        run_to_halt("directed");
        chk("first_fetch_cycle", 96'(fc[0]), 96'd1);
        chk("first_valid_cycle", 96'(first_iv), 96'd4);
        chk("first_issue_fields", 96'(first_iss), 96'({4'hA, 4'h1, 32'd3, 32'd33, 8'h00}));
        chk("second_fetch_cycle", 96'(fc[1]), 96'd5);
        chk("stall_cycles", 96'(low_cnt), 96'd5);
        chk("stalled_accept_cycle", 96'(acc[1]), 96'd13);
        chk("post_stall_fetch_cycle", 96'(fc[2]), 96'd14);

        // Directed branch at 4 -> 0x10.
        fill_alu();
        mem[4]     = 32'hC0000010;
        mem[8'h11] = 32'hF0000000;
        rmode      = 1;
        do_reset();
        run_to_halt("branch");
        chk("branch_issue_count", 96'(nacc), 96'd5);

        for (int p = 0; p < 6; p++) begin
            gen_random();
            do_reset();
            run_to_halt($sformatf("rand%0d", p));
        end

        // Reset pulsed while u1 (RAM_LAT=3) is waiting on RAM.
        gen_random();
        do_reset();
        for (int n = 0; n < 20; n++) begin
            step();
            if (fr[1]) break;
        end
        chk("abort_pre_fetch", 96'(fr[1]), 96'd1);
        step();
        reset = 1'b1;
        flush();
        step();
        release_and_check();
        run_to_halt("abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
